// File: rtl/outbox_drain.sv
// outbox_drain: pops bytes from the hrmcpu OUTBOX, buffers them in a small queue,
// and presents them downstream on valid/ready while counting delivered bytes.
module outbox_drain #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     drain_en,
    input  logic                     cpu_out_empty,
    input  logic [7:0]               cpu_out_data,
    output logic                     cpu_out_rd,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   q_level,
    output logic [CNT_W-1:0]         drained_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_POPPED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             cap_q;
    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      level_q, level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [AW+1:0]    occ;
    logic             acc, go;

    // Credit counts the byte still landing so a pop never targets a full queue.
    always_comb begin
        acc     = tx_valid & tx_ready;
        occ     = {1'b0, level_q} + {{(AW + 1){1'b0}}, cap_q};
        go      = (state_q == ST_IDLE) && drain_en && !cpu_out_empty && (occ < (AW + 2)'(DEPTH));
        state_d = go ? ST_POPPED : ST_IDLE;
        level_d = level_q + {{AW{1'b0}}, cap_q} - {{AW{1'b0}}, acc};
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cap_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= (state_q == ST_POPPED);
            level_q <= level_d;
            if (cap_q) begin
                mem_q[wptr_q] <= cpu_out_data;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (acc) begin
                rptr_q <= rptr_q + AW'(1);
                cnt_q  <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign cpu_out_rd  = (state_q == ST_POPPED);
    assign tx_valid    = (level_q != '0);
    assign tx_data     = mem_q[rptr_q];
    assign q_level     = level_q;
    assign drained_cnt = cnt_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (i_rst)
        !(cap_q && !acc && level_q == (AW + 1)'(DEPTH)));
endmodule

// File: tb/tb_outbox_drain.sv
// tb_outbox_drain: drives outbox_drain from a modelled OUTBOX and checks delivery order,
// occupancy, pop spacing and the wrapping drained-byte counter.
module tb_outbox_drain;
    logic       clk, i_rst, drain_en, cpu_out_empty, cpu_out_rd, tx_valid, tx_ready;
    logic [7:0] cpu_out_data, tx_data;
    logic [2:0] q_level;
    logic [3:0] drained_cnt;

    outbox_drain #(.DEPTH(4), .CNT_W(4)) dut (
        .clk(clk), .i_rst(i_rst), .drain_en(drain_en), .cpu_out_empty(cpu_out_empty),
        .cpu_out_data(cpu_out_data), .cpu_out_rd(cpu_out_rd), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .q_level(q_level), .drained_cnt(drained_cnt)
    );

    typedef struct {
        logic       push;
        logic [7:0] b;
        logic       en;
        logic       rdy;
        logic       rd;
        logic       v;
        logic [7:0] d;
        logic [2:0] lvl;
        logic [3:0] cnt;
    } vec_t;

    int         total = 0, bad = 0, pops = 0, pushed = 0;
    logic [7:0] ob[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_acc;
    int         lvl_m;
    logic [3:0] cnt_m;
    logic       h0, h1, acc_prev, rd_prev;
    vec_t       tbl[14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic push(input logic [7:0] b);
        ob.push_back(b);
        cpu_out_empty = 1'b0;
        pushed++;
    endtask

    // OUTBOX model: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        if (cpu_out_rd) begin
            chk("rd_nonempty", 32'(ob.size() != 0), 1);
            if (ob.size() != 0) begin
                cpu_out_data <= ob[0];
                exp_q.push_back(ob.pop_front());
                pops++;
                cpu_out_empty <= (ob.size() == 0);
            end
        end
    end

    // Reference: entries land two samples after a pop strobe, leave one sample after accept.
    always @(negedge clk) begin
        if (i_rst) begin
            exp_q.delete();
            lvl_m = 0; cnt_m = '0; h0 = 0; h1 = 0; acc_prev = 0; rd_prev = 0;
        end else begin
            lvl_m = lvl_m + int'(h1) - int'(acc_prev);
            cnt_m = cnt_m + 4'(acc_prev);
            chk("level", 32'(q_level), 32'(lvl_m));
            chk("valid", 32'(tx_valid), 32'(lvl_m != 0));
            chk("cnt", 32'(drained_cnt), 32'(cnt_m));
            chk("rd_gap", 32'(cpu_out_rd && rd_prev), 0);
            if (tx_valid && tx_ready) begin
                chk("order_avail", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("order_data", 32'(tx_data), 32'(exp_q.pop_front()));
                last_acc = tx_data;
            end
            h1 = h0; h0 = cpu_out_rd; rd_prev = cpu_out_rd;
            acc_prev = tx_valid && tx_ready;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        i_rst = 1; drain_en = 0; tx_ready = 0;
        ob.delete(); cpu_out_empty = 1; pops = 0; pushed = 0;
        @(negedge clk);
        chk("rst_rd", 32'(cpu_out_rd), 0);
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_level", 32'(q_level), 0);
        chk("rst_cnt", 32'(drained_cnt), 0);
        @(posedge clk); #1;
        i_rst = 0;
    endtask

    task automatic wait_rd(input string nm, input int lim);
        logic done = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (cpu_out_rd) begin done = 1; break; end
        end
        chk({nm, "_seen"}, 32'(done), 1);
    endtask

    task automatic wait_drain(input string nm, input int lim);
        logic done = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (ob.size() == 0 && exp_q.size() == 0 && q_level == 0 && !cpu_out_rd) begin
                done = 1; break;
            end
        end
        chk({nm, "_drained"}, 32'(done), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 8'h2A, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'd0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 4'd0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'd0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h2A, 3'd1, 4'd0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'd1};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'd1};
        tbl[6]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'd1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'd1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'd1};
        tbl[9]  = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 4'd1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'd1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 3'd1, 4'd1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'd2};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 4'd2};
        i_rst = 1; drain_en = 0; tx_ready = 0; cpu_out_empty = 1; cpu_out_data = '0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (tbl[i].push) push(tbl[i].b);
            drain_en = tbl[i].en;
            tx_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_rd", i), 32'(cpu_out_rd), 32'(tbl[i].rd));
            chk($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d_level", i), 32'(q_level), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d_cnt", i), 32'(drained_cnt), 32'(tbl[i].cnt));
            if (tbl[i].v) chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(tbl[i].d));
        end

        do_reset();
        drain_en = 1; tx_ready = 1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_drain("stream", 60);
        chk("stream_cnt", 32'(drained_cnt), 8);
        chk("stream_last", 32'(last_acc), 8);
        chk("stream_pops", 32'(pops), 8);

        do_reset();
        drain_en = 1;
        for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
        repeat (20) @(negedge clk);
        chk("bp_pops", 32'(pops), 4);
        chk("bp_level", 32'(q_level), 4);
        chk("bp_head", 32'(tx_data), 32'h10);
        chk("bp_left", 32'(ob.size()), 2);
        @(posedge clk); #1; tx_ready = 1;
        @(posedge clk); #1; tx_ready = 0;
        wait_rd("sim", 10);
        @(posedge clk); #1; tx_ready = 1;
        @(negedge clk);
        chk("sim_level_pre", 32'(q_level), 3);
        @(posedge clk); #1; tx_ready = 0;
        @(negedge clk);
        chk("sim_level_post", 32'(q_level), 3);
        chk("sim_head", 32'(tx_data), 32'h12);
        tx_ready = 1;
        wait_drain("bp", 80);
        chk("bp_cnt", 32'(drained_cnt), 6);
        chk("bp_last", 32'(last_acc), 32'h15);

        do_reset();
        drain_en = 1; tx_ready = 1;
        push(8'hA1); push(8'hA2);
        wait_rd("mid", 10);
        @(posedge clk); #1; i_rst = 1; #1;
        chk("mid_rd", 32'(cpu_out_rd), 0);
        chk("mid_valid", 32'(tx_valid), 0);
        chk("mid_data", 32'(tx_data), 0);
        chk("mid_level", 32'(q_level), 0);
        chk("mid_cnt", 32'(drained_cnt), 0);
        @(posedge clk); #1; i_rst = 0;
        wait_drain("mid", 60);
        chk("mid_cnt_after", 32'(drained_cnt), 1);
        chk("mid_byte", 32'(last_acc), 32'hA2);
        chk("mid_pops", 32'(pops), 2);

        do_reset();
        drain_en = 1; tx_ready = 1;
        for (int i = 0; i < 17; i++) push(8'($urandom_range(0, 255)));
        wait_drain("wrap", 120);
        chk("wrap_cnt", 32'(drained_cnt), 1);
        chk("wrap_pops", 32'(pops), 17);

        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            drain_en = ($urandom_range(0, 7) != 0);
            tx_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) push(8'($urandom_range(0, 255)));
        end
        drain_en = 1; tx_ready = 1;
        wait_drain("rand", 400);
        chk("rand_cnt", 32'(drained_cnt), 32'(pushed % 16));
        chk("rand_pops", 32'(pops), 32'(pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
